alu_operand_issue: RTL and testbench

- Execute-issue stage directly upstream of the 32-bit ALU (6-bit ALUFN; flags z/v/n).
- Decodes a Beta-format ALU instruction and reads operands from an internal 32x32 register file.
- Selects register or sign-extended literal for B, and presents registered `alufn`/`a`/`b` to the ALU with a valid/ready handshake.
- Also owns the register-file writeback port, so ALU results return here.

---
 rtl/alu_operand_issue.sv | 159 +++++++++++++++
 tb/tb_alu_operand_issue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// Execute-issue stage ahead of the 32-bit ALU: decodes Beta ALU instructions,
// reads operands from a local register file (with writeback bypass) and issues them.
module alu_operand_issue #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_alufn,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [4:0]       out_rc,
    output logic             out_illegal,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    localparam logic [4:0] ZERO_IDX = 5'd31;

    // Returns {legal, alufn}; only opcodes 0x20-0x3F with a supported low nibble are legal.
    function automatic logic [6:0] decode_alufn(input logic [5:0] opcode);
        logic [6:0] res;
        res = 7'b0000000;
        if (opcode[5] == 1'b1) begin
            case (opcode[3:0])
                4'h0:    res = {1'b1, 6'b000000};
                4'h1:    res = {1'b1, 6'b000001};
                4'h2:    res = {1'b1, 6'b000010};
                4'h4:    res = {1'b1, 6'b110011};
                4'h5:    res = {1'b1, 6'b110101};
                4'h6:    res = {1'b1, 6'b110111};
                4'h8:    res = {1'b1, 6'b011000};
                4'h9:    res = {1'b1, 6'b011110};
                4'hA:    res = {1'b1, 6'b010110};
                4'hC:    res = {1'b1, 6'b100000};
                4'hD:    res = {1'b1, 6'b100001};
                4'hE:    res = {1'b1, 6'b100011};
                default: res = 7'b0000000;
            endcase
        end else begin
            res = 7'b0000000;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] regs_r [NREGS];

    logic             valid_r;
    logic [5:0]       alufn_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [4:0]       rc_r;
    logic             illegal_r;

    logic [5:0]       opcode_s;
    logic [4:0]       rc_s;
    logic [4:0]       ra_s;
    logic [4:0]       rb_s;
    logic [6:0]       dec_s;
    logic [WIDTH-1:0] ra_val_s;
    logic [WIDTH-1:0] rb_val_s;
    logic [WIDTH-1:0] lit_s;
    logic [5:0]       issue_alufn_s;
    logic [WIDTH-1:0] issue_a_s;
    logic [WIDTH-1:0] issue_b_s;
    logic             accept_s;

    assign opcode_s = in_instr[31:26];
    assign rc_s     = in_instr[25:21];
    assign ra_s     = in_instr[20:16];
    assign rb_s     = in_instr[15:11];
    assign lit_s    = {{(WIDTH-16){in_instr[15]}}, in_instr[15:0]};
    assign dec_s    = decode_alufn(opcode_s);

    assign in_ready = ~valid_r | out_ready;
    assign accept_s = in_valid & in_ready;

    // Register reads with same-cycle writeback forwarding; index 31 is hardwired zero.
    always_comb begin
        ra_val_s = '0;
        rb_val_s = '0;
        if (ra_s == ZERO_IDX) begin
            ra_val_s = '0;
        end else if (wb_en && (wb_addr == ra_s)) begin
            ra_val_s = wb_data;
        end else begin
            ra_val_s = regs_r[ra_s];
        end
        if (rb_s == ZERO_IDX) begin
            rb_val_s = '0;
        end else if (wb_en && (wb_addr == rb_s)) begin
            rb_val_s = wb_data;
        end else begin
            rb_val_s = regs_r[rb_s];
        end
    end

    // Operand selection; illegal ops issue with zeroed function and operands.
    always_comb begin
        issue_alufn_s = 6'b000000;
        issue_a_s     = '0;
        issue_b_s     = '0;
        if (dec_s[6]) begin
            issue_alufn_s = dec_s[5:0];
            issue_a_s     = ra_val_s;
            issue_b_s     = opcode_s[4] ? lit_s : rb_val_s;
        end else begin
            issue_alufn_s = 6'b000000;
            issue_a_s     = '0;
            issue_b_s     = '0;
        end
    end

    // Register file write port, active independent of the issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_addr != ZERO_IDX)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Issue register: load on accept, drop valid on consume, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            alufn_r   <= 6'b000000;
            a_r       <= '0;
            b_r       <= '0;
            rc_r      <= 5'd0;
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            valid_r   <= 1'b1;
            alufn_r   <= issue_alufn_s;
            a_r       <= issue_a_s;
            b_r       <= issue_b_s;
            rc_r      <= rc_s;
            illegal_r <= ~dec_s[6];
        end else if (out_ready) begin
            valid_r   <= 1'b0;
        end
    end

    assign out_valid   = valid_r;
    assign out_alufn   = alufn_r;
    assign out_a       = a_r;
    assign out_b       = b_r;
    assign out_rc      = rc_r;
    assign out_illegal = illegal_r;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: driver pushes expected issues from a
// table-driven reference model, a negedge monitor pops and compares on consume.
module tb_alu_operand_issue;

    typedef struct packed {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rc;
        logic        ill;
    } item_t;

    localparam int FN_TAB [16] = '{0, 1, 2, -1, 51, 53, 55, -1, 24, 30, 22, -1, 32, 33, 35, -1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_alufn;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rc;
    logic        out_illegal;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    item_t       q [$];
    logic        exp_valid = 1'b0;
    logic        prev_stall = 1'b0;
    item_t       prev_out;

    alu_operand_issue #(.NREGS(32), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alufn(out_alufn), .out_a(out_a), .out_b(out_b),
        .out_rc(out_rc), .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] mkl(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    function automatic logic [31:0] rd(input int idx, input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd);
        if (idx == 31) return 32'd0;
        if (we && int'(wa) == idx) return wd;
        return model[idx];
    endfunction

    function automatic item_t model_issue(input logic [31:0] instr, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        item_t it;
        int op;
        int fn;
        logic [15:0] lit;
        op  = int'(instr[31:26]);
        lit = instr[15:0];
        fn  = FN_TAB[op % 16];
        it.rc = instr[25:21];
        if (op >= 32 && fn >= 0) begin
            it.ill = 1'b0;
            it.fn  = 6'(fn);
            it.a   = rd(int'(instr[20:16]), we, wa, wd);
            if (op >= 48) it.b = {{16{lit[15]}}, lit};
            else          it.b = rd(int'(instr[15:11]), we, wa, wd);
        end else begin
            it.ill = 1'b1;
            it.fn  = 6'd0;
            it.a   = 32'd0;
            it.b   = 32'd0;
        end
        return it;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One cycle of stimulus; entered and left just after a rising edge.
    task automatic drive(input logic v, input logic [31:0] instr, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        logic  exp_rdy;
        logic  acc;
        logic  nxt;
        item_t it;
        in_valid = v; in_instr = instr; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
        #1;
        exp_rdy = !exp_valid || ordy;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        acc = v && exp_rdy;
        it  = model_issue(instr, we, wa, wd);
        nxt = acc ? 1'b1 : ((exp_valid && ordy) ? 1'b0 : exp_valid);
        @(posedge clk);
        exp_valid = nxt;
        if (acc) q.push_back(it);
        if (we && wa != 5'd31) model[wa] = wd;
        #1;
    endtask

    // Monitor: valid tracking, stall stability and scoreboard pop on consume.
    always @(negedge clk) begin
        item_t cur;
        item_t exp;
        cur = '{out_alufn, out_a, out_b, out_rc, out_illegal};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            if (prev_stall && out_valid) check("stall_hold", 64'(cur), 64'(prev_out));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scoreboard_empty: got issue %h expected none", cur);
                end else begin
                    exp = q.pop_front();
                    check("issue", 64'(cur), 64'(exp));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #3;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outs", {23'd0, out_alufn, out_a, out_b, out_rc, out_illegal}, 64'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;

        drive(1'b1, mk(6'h20, 5'd4, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 5'd1, 32'hffffff68, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 5'd2, 32'hffffff34, 1'b1);
        drive(1'b1, mk(6'h21, 5'd3, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b1, mkl(6'h3E, 5'd4, 5'd1, 16'h8000), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b1, mk(6'h2C, 5'd4, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b1, mk(6'h24, 5'd7, 5'd5, 5'd5), 1'b1, 5'd5, 32'h0a0a0a0a, 1'b1);
        drive(1'b1, mk(6'h20, 5'd6, 5'd31, 5'd31), 1'b1, 5'd31, 32'hdeadbeef, 1'b1);

        // Backpressure: one held op, three blocked cycles, then four back-to-back.
        drive(1'b1, mk(6'h28, 5'd8, 5'd1, 5'd5), 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, mk(6'h29, 5'd9, 5'd2, 5'd5), 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, mk(6'h2A, 5'(10 + i), 5'(i), 5'd5), 1'b0, 5'd0, 32'd0, 1'b1);

        drive(1'b1, mk(6'h23, 5'd11, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b1, mk(6'h00, 5'd12, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b1, mk(6'h22, 5'd13, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);

        // Reset in the middle of a stall.
        drive(1'b1, mk(6'h25, 5'd14, 5'd1, 5'd2), 1'b1, 5'd20, 32'h12345678, 1'b0);
        drive(1'b1, mk(6'h26, 5'd15, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_valid = 1'b0;
        q.delete();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_outs", {23'd0, out_alufn, out_a, out_b, out_rc, out_illegal}, 64'd0);
        @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, mk(6'h20, 5'd1, 5'd20, 5'd1), 1'b0, 5'd0, 32'd0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) < 8) op = {1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            else op = 6'($urandom_range(0, 63));
            drive($urandom_range(0, 3) != 0,
                  {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom)},
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 32'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        for (int n = 0; n < 20; n++) begin
            if (q.size() == 0 && !exp_valid) break;
            drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        end
        check("drain", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
